// File: rtl/des_spi_master.sv
// des_spi_master -- SPI mode-0 master, host side of the DES core's SPI slave link.
//
// Every transaction is full duplex and DATA_W bits long, MSB first: tx_data
// goes out on mosi and miso is captured into rx_data. A plaintext write sends
// the plaintext; a ciphertext read sends all zeros.
//
// Valid/ready contract: start acts as "valid" and !busy as "ready". A start
// is accepted only on a cycle where busy=0; tx_data is captured on that cycle.
// busy stays high until the end of the post-transaction gap. A start that
// arrives while busy=1 is dropped, not queued. done pulses for one cycle when
// rx_data holds the captured word; rx_data then holds until the next done.
//
// Parameters:
//   DATA_W  bits per transaction (>=2)
//   CLK_DIV sclk half-period in clk cycles (>=1)
//   CS_GAP  minimum clk cycles cs_n stays high between transactions (>=1)
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       asynchronous reset, active low
//   start     transaction request
//   tx_data   word to send
//   busy      transaction (or trailing gap) in progress
//   done      one-cycle pulse, rx_data valid
//   rx_data   word captured from miso
//   sclk      SPI clock, idle low
//   cs_n      chip select, active low
//   mosi      master data out
//   miso      slave data in
//   dbg_state current FSM state (IDLE=0 SETUP=1 SHIFT=2 HOLD=3 GAP=4)
//
// Build option: SPI_MASTER_LOOPBACK_EN -- when defined, the shift register
// captures the internal mosi register instead of the miso pin, so rx_data
// equals tx_data. Pin behaviour is unchanged.

module des_spi_master #(
  parameter int DATA_W  = 64,
  parameter int CLK_DIV = 5,
  parameter int CS_GAP  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              tick;
  logic              cap_bit;

  assign tick      = (div_cnt == DIV_LAST);
  assign dbg_state = state;

`ifdef SPI_MASTER_LOOPBACK_EN
  // mosi already holds the bit being clocked out on this rising edge.
  assign cap_bit = mosi;
`else
  assign cap_bit = miso;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Half-period timer runs only through the active phases.
      if (state == S_SETUP || state == S_SHIFT || state == S_HOLD) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            // cs_n and the first data bit are set up on the accepting edge so
            // mosi has a full SETUP phase plus one half-period before rising sclk.
            shift_reg <= tx_data;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= tx_data[DATA_W-1];
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (!sclk) begin
              // Rising toggle: capture the incoming bit.
              shift_reg <= {shift_reg[DATA_W-2:0], cap_bit};
              bit_cnt   <= bit_cnt + BIT_W'(1);
            end else if (bit_cnt == BIT_ALL) begin
              state <= S_HOLD;
            end else begin
              // Falling toggle: after the shift, the next bit to send is the MSB.
              mosi <= shift_reg[DATA_W-1];
            end
          end
        end

        S_HOLD: begin
          if (tick) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rx_data <= shift_reg;
            done    <= 1'b1;
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_spi_master.sv
// Testbench for des_spi_master: behavioural SPI slave, stimulus driver,
// scoreboard of expected words per accepted transaction, and a negedge monitor.
module tb_des_spi_master;

  localparam int W       = 64;
  localparam int CLK_DIV = 5;
  localparam int CS_GAP  = 20;
  localparam int LAT     = CLK_DIV * (2 * W + 2) + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] tx_data;
  logic         busy;
  logic         done;
  logic [W-1:0] rx_data;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [2:0]   dbg_state;

  des_spi_master #(.DATA_W(W), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];   // expected rx_data
  logic [W-1:0] tx_q[$];    // word the slave must receive
  int           acc_q[$];   // accepting clk edge (cyc value)
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout or unexpected event (cyc %0d)", name, cyc);
  endtask

  // ---------------- behavioural SPI slave ----------------
  logic [W-1:0] slave_resp = '0;
  logic [W-1:0] slave_rx   = '0;
  logic         slave_bit  = 1'b0;
  int           bit_idx    = 0;
  int           rise_cnt   = 0;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign miso = 1'b1;
`else
  assign miso = slave_bit;
`endif

  always @(negedge cs_n) begin
    bit_idx   = 0;
    rise_cnt  = 0;
    slave_rx  = '0;
    slave_bit = slave_resp[W-1];
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      slave_rx = {slave_rx[W-2:0], mosi};
      rise_cnt++;
    end
  end

  always @(negedge sclk) begin
    if (!cs_n) begin
      bit_idx++;
      if (bit_idx < W) slave_bit = slave_resp[W-1-bit_idx];
    end
  end

  // ---------------- monitor ----------------
  logic prev_busy = 1'b0;
  logic prev_csn  = 1'b1;
  logic prev_sclk = 1'b0;
  logic prev_mosi = 1'b0;
  int   last_done = 0;
  int   last_rise_csn = -1000;
  int   last_mosi_chg = 0;
  int   viol = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_busy     = 1'b0;
      prev_csn      = 1'b1;
      prev_sclk     = 1'b0;
      prev_mosi     = 1'b0;
      last_rise_csn = -1000;
    end else begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          logic [W-1:0] e_rx;
          logic [W-1:0] e_tx;
          int           acc;
          e_rx = exp_q.pop_front();
          e_tx = tx_q.pop_front();
          acc  = acc_q.pop_front();
          check("rx_data", rx_data, e_rx);
          check("slave_word", slave_rx, e_tx);
          check("rise_edges", W'(rise_cnt), W'(W));
          check("latency", W'(cyc - acc + 1), W'(LAT));
          check("mosi_setup_viol", W'(viol), '0);
        end
        last_done = cyc;
      end
      if (prev_busy && !busy) check("busy_fall_after_done", W'(cyc - last_done), W'(CS_GAP));
      if (!prev_csn && cs_n) last_rise_csn = cyc;
      if (prev_csn && !cs_n) begin
        check("cs_gap_ok", W'((cyc - last_rise_csn) >= CS_GAP + 1), W'(1));
        viol = 0;
      end
      if (mosi !== prev_mosi) last_mosi_chg = cyc;
      if (sclk && !prev_sclk && (cyc - last_mosi_chg) < CLK_DIV) viol++;
      prev_busy = busy;
      prev_csn  = cs_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [W-1:0] tx, input logic [W-1:0] resp, output int acc);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      fail_now("wait_not_busy");
      acc = -1;
      return;
    end
    slave_resp = resp;
    tx_data    = tx;
    start      = 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
    exp_q.push_back(tx);
`else
    exp_q.push_back(resp);
`endif
    tx_q.push_back(tx);
    acc_q.push_back(cyc + 1);
    acc = cyc + 1;
    @(negedge clk);
    start   = 1'b0;
    tx_data = {$urandom, $urandom};   // post-acceptance changes must not matter
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start_at(input int target);
    wait_until_cyc(target);
    tx_data = {$urandom, $urandom};
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) fail_now("drain");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p;
    int guard;
    rst     = 1'b0;
    start   = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_sclk", W'(sclk), '0);
    check("reset_cs_n", W'(cs_n), W'(1));
    check("reset_mosi", W'(mosi), '0);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_rx_data", rx_data, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write and read.
    issue(64'hFEDC_BA98_7654_3210, {$urandom, $urandom}, p);
    wait_drain();
    issue(64'h0, 64'h0123_4567_89AB_CDEF, p);
    wait_drain();

    // Busy guard: extra starts during the transfer, on done and in GAP.
    issue({$urandom, $urandom}, {$urandom, $urandom}, p);
    pulse_start_at(p + 9);
    pulse_start_at(p + 650);
    pulse_start_at(p + 659);
    wait_until_cyc(p + 669);
    check("busy_cycle_670", W'(busy), W'(1));
    wait_until_cyc(p + 670);
    check("busy_cycle_671", W'(busy), '0);
    // Back-to-back: start on the first cycle busy is low.
    issue({$urandom, $urandom}, {$urandom, $urandom}, p);
    wait_drain();

    // Reset in the middle of a transfer.
    issue({$urandom, $urandom}, {$urandom, $urandom}, p);
    guard = 0;
    while (rise_cnt != 30 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) fail_now("wait_rise_30");
    #1 rst = 1'b0;
    #1;
    check("abort_cs_n", W'(cs_n), W'(1));
    check("abort_sclk", W'(sclk), '0);
    check("abort_mosi", W'(mosi), '0);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_rx_data", rx_data, '0);
    exp_q.delete();
    tx_q.delete();
    acc_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue({$urandom, $urandom}, {$urandom, $urandom}, p);
    wait_drain();

    // Randomized traffic with ignored starts sprinkled in while busy.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        issue(64'h0, {$urandom, $urandom}, p);
      else
        issue({$urandom, $urandom}, {$urandom, $urandom}, p);
      if ($urandom_range(0, 1) == 1) pulse_start_at(p + $urandom_range(1, 665));
    end
    wait_drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
